// File: rtl/wordle_scorer.sv
// wordle_scorer
// Scores a latched 5-letter guess against the word of the day in two passes:
// an exact-match pass (one position per clock) and then a present-elsewhere
// pass (one guess/answer letter pair per clock). Duplicate letters score as
// in the real game. Latency does not depend on the data.
//
// Ports
//   Clk     system clock
//   reset   asynchronous, active-high reset
//   Start   request to score; sampled only while idle
//   guess   guessed word, letter 0 in the top LW bits
//   answer  word of the day, same packing
//   busy    high from the accepting edge through the done cycle
//   done    one-cycle pulse; score and win are valid
//   score   2 bits per letter, letter 0 in the top bits
//           (00 gray, 01 yellow, 10 green)
//   win     every letter green; held until the next accepted Start
//
// state    | meaning
// S_IDLE   | waiting for Start; the last result stays on score/win
// S_GREEN  | exact-match pass, position i
// S_YELLOW | present-elsewhere pass, guess letter i against answer letter j
// S_DONE   | one-cycle done pulse
module wordle_scorer #(
    parameter int N  = 5,
    parameter int LW = 8
) (
    input  logic            Clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [N*LW-1:0] guess,
    input  logic [N*LW-1:0] answer,
    output logic            busy,
    output logic            done,
    output logic [2*N-1:0]  score,
    output logic            win
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    localparam logic [1:0] GRAY   = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N*LW-1:0] g_q, g_d;
    logic [N*LW-1:0] a_q, a_d;
    logic [1:0]      sc_q [N];
    logic [1:0]      sc_d [N];
    logic [N-1:0]    used_q, used_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   j_q, j_d;
    logic            win_q, win_d;

    logic [LW-1:0]   g_let [N];
    logic [LW-1:0]   a_let [N];
    logic            all_green;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            g_let[k] = g_q[(N-1-k)*LW +: LW];
            a_let[k] = a_q[(N-1-k)*LW +: LW];
        end
    end

    // The yellow pass only ever turns gray into yellow, so the green set is
    // final once the exact-match pass ends and can be judged from sc_q.
    always_comb begin
        all_green = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sc_q[k] != GREEN) all_green = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        a_d     = a_q;
        sc_d    = sc_q;
        used_d  = used_q;
        i_d     = i_q;
        j_d     = j_q;
        win_d   = win_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    g_d     = guess;
                    a_d     = answer;
                    sc_d    = '{default: GRAY};
                    used_d  = '0;
                    win_d   = 1'b0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_GREEN;
                end
            end
            S_GREEN: begin
                if (g_let[i_q] == a_let[i_q]) begin
                    sc_d[i_q]   = GREEN;
                    used_d[i_q] = 1'b1;
                end
                if (i_q == LAST) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_YELLOW;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_YELLOW: begin
                // Once a letter is yellow its field is no longer gray, so later
                // j for the same i cannot claim a second answer letter.
                if (sc_q[i_q] == GRAY && !used_q[j_q] &&
                    g_let[i_q] == a_let[j_q]) begin
                    sc_d[i_q]   = YELLOW;
                    used_d[j_q] = 1'b1;
                end
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        win_d   = all_green;
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            a_q     <= '0;
            sc_q    <= '{default: GRAY};
            used_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            a_q     <= a_d;
            sc_q    <= sc_d;
            used_q  <= used_d;
            i_q     <= i_d;
            j_q     <= j_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        score = '0;
        for (int k = 0; k < N; k++) begin
            score[2*(N-1-k) +: 2] = sc_q[k];
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign win  = win_q;

endmodule

// File: tb/tb_wordle_scorer.sv
module tb_wordle_scorer;

    logic        Clk;
    logic        reset;
    logic        Start;
    logic [39:0] guess;
    logic [39:0] answer;
    logic        busy;
    logic        done;
    logic [9:0]  score;
    logic        win;

    int tests = 0;
    int fails = 0;

    wordle_scorer #(.N(5), .LW(8)) dut (
        .Clk    (Clk),
        .reset  (reset),
        .Start  (Start),
        .guess  (guess),
        .answer (answer),
        .busy   (busy),
        .done   (done),
        .score  (score),
        .win    (win)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Game rules: greens first, then each non-green guess letter takes the
    // leftmost still-unclaimed matching answer letter.
    function automatic logic [9:0] ref_score(input logic [39:0] g, input logic [39:0] a);
        byte gl [5];
        byte al [5];
        int  code [5];
        bit  claimed [5];
        logic [9:0] r;
        for (int k = 0; k < 5; k++) begin
            gl[k] = g[39-8*k -: 8];
            al[k] = a[39-8*k -: 8];
            code[k] = 0;
            claimed[k] = 0;
        end
        for (int k = 0; k < 5; k++)
            if (gl[k] == al[k]) begin
                code[k] = 2;
                claimed[k] = 1;
            end
        for (int k = 0; k < 5; k++) begin
            if (code[k] != 0) continue;
            for (int m = 0; m < 5; m++)
                if (!claimed[m] && gl[k] == al[m]) begin
                    code[k] = 1;
                    claimed[m] = 1;
                    break;
                end
        end
        r = '0;
        for (int k = 0; k < 5; k++) r[9-2*k -: 2] = 2'(code[k]);
        return r;
    endfunction

    function automatic logic [39:0] rand_word();
        logic [39:0] w;
        for (int k = 0; k < 5; k++) w[8*k +: 8] = 8'h41 + 8'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic run_op(input logic [39:0] g, input logic [39:0] a, input string tag,
                          input logic [9:0] fixed_exp, input bit use_fixed);
        logic [9:0] exp_sc;
        int lat;
        exp_sc = ref_score(g, a);
        if (use_fixed) check({tag, "_model"}, 32'(exp_sc), 32'(fixed_exp));
        guess  = g;
        answer = a;
        Start  = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start  = 1'b0;
        guess  = ~g;
        answer = ~a;
        lat = 0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && lat < 100) begin
            @(negedge Clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd30);
        check({tag, "_score"}, 32'(score), 32'(exp_sc));
        check({tag, "_win"}, 32'(win), 32'(exp_sc == 10'h2AA));
        @(negedge Clk);
        check({tag, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_hold"}, 32'(score), 32'(exp_sc));
    endtask

    initial begin
        logic [39:0] g, a;
        logic [9:0]  sc_at_done;
        int lat, ndone, d1;

        reset  = 1'b1;
        Start  = 1'b0;
        guess  = '0;
        answer = '0;
        repeat (2) @(negedge Clk);
        check("reset_state", {20'd0, busy, done, score}, 32'd0);
        check("reset_win", 32'(win), 32'd0);
        reset = 1'b0;
        @(negedge Clk);

        run_op("ROBOT", "ROBOT", "exact", 10'b1010101010, 1'b1);
        run_op("ZZZZZ", "CRIMP", "none",  10'b0000000000, 1'b1);
        run_op("OOOOO", "ROBOT", "dup_green", 10'b0010001000, 1'b1);
        run_op("BOBBY", "ABBOT", "dup_yellow", 10'b0101100000, 1'b1);

        // Start re-pulsed mid-operation with a different guess
        g = "BOBBY"; a = "ABBOT";
        guess = g; answer = a; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        lat = 0; ndone = 0; d1 = -1; sc_at_done = '0;
        while (lat < 45) begin
            @(negedge Clk);
            lat++;
            if (lat == 10) begin Start = 1'b1; guess = "ROBOT"; answer = "ROBOT"; end
            if (lat == 11) Start = 1'b0;
            if (done === 1'b1) begin ndone++; d1 = lat; sc_at_done = score; end
        end
        check("repulse_ndone", 32'(ndone), 32'd1);
        check("repulse_latency", 32'(d1), 32'd30);
        check("repulse_score", 32'(sc_at_done), 32'(ref_score(g, a)));

        // Reset in the middle of an operation
        guess = "ROBOT"; answer = "ROBOT"; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (15) @(negedge Clk);
        reset = 1'b1;
        #1;
        check("midreset_outputs", {20'd0, busy, done, score}, 32'd0);
        check("midreset_win", 32'(win), 32'd0);
        @(negedge Clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge Clk);
            if (done === 1'b1) ndone++;
        end
        check("midreset_no_done", 32'(ndone), 32'd0);
        run_op("ROBOT", "ROBOT", "after_reset", 10'b1010101010, 1'b1);

        // Start held high: back-to-back operations
        g = "CABAD"; a = "ABACA";
        guess = g; answer = a; Start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        lat = 0; ndone = 0; d1 = -1;
        while (ndone < 2 && lat < 100) begin
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) d1 = lat;
                else begin
                    Start = 1'b0;
                    check("b2b_spacing", 32'(lat - d1), 32'd32);
                    check("b2b_score", 32'(score), 32'(ref_score(g, a)));
                end
            end
            if (ndone < 2) begin
                @(negedge Clk);
                lat++;
            end
        end
        Start = 1'b0;
        check("b2b_first_latency", 32'(d1), 32'd30);
        check("b2b_count", 32'(ndone), 32'd2);
        repeat (2) @(negedge Clk);
        check("b2b_idle", 32'(busy), 32'd0);

        // Random words over a small alphabet to force duplicates
        for (int t = 0; t < 20; t++) begin
            g = rand_word();
            a = (t % 5 == 0) ? g : rand_word();
            run_op(g, a, $sformatf("rand%0d", t), '0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wordle_scorer.md
Name: wordle_scorer

Overview:
- Downstream scoring stage for the Wordle guess state machine. Consumes the committed 5-letter guess and the word of the day.
- Produces per-letter colour codes (green/yellow/gray) plus a win flag, which drive the display/LED stage.
- Uses a sequential two-pass algorithm (exact-match pass, then present-elsewhere pass) so duplicate letters score exactly as in the real game.
- Fixed, data-independent latency.

Parameters:
- N, 5, letters per word.
- LW, 8, bits per letter (ASCII uppercase).

Ports:
- Clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- Start  input  1  request to score; sampled only in IDLE.
- guess  input  N*LW  guessed word; letter 0 = guess[N*LW-1 -: LW] (first/leftmost letter).
- answer  input  N*LW  word of the day, same packing.
- busy  output  1  high from the accepting edge until DONE exits.
- done  output  1  one-cycle pulse: score/win valid.
- score  output  2*N  per-letter code, letter 0 in score[2N-1:2N-2]; 00 gray, 01 yellow, 10 green, 11 never produced.
- win  output  1  all letters green; valid with done, held thereafter.

Behaviour:
- Reset (async): state IDLE, busy=0, done=0, score=0, win=0, used/index registers cleared.
- States: IDLE, GREEN, YELLOW, DONE.
- IDLE:
  - Start=1 at edge E0 latches guess and answer into internal registers, clears score, win, and the N-bit used vector, sets i=0, and goes to GREEN.
  - Inputs may change freely after E0.
- GREEN: one position per edge, i=0..N-1.
  - If g[i]==a[i]: score[i]=10, used[i]=1.
  - After i=N-1: go to YELLOW with i=0, j=0.
- YELLOW: one (i,j) pair per edge; i outer, j inner, N*N edges total.
  - Pair qualifies if score[i]==00 and used[j]==0 and g[i]==a[j]. Green and already-yellow letters never qualify.
  - On a qualifying pair: score[i]=01, used[j]=1. The first qualifying j wins; later j for the same i are blocked because score[i] is no longer 00.
  - The scan always runs the full N*N pairs; there is no early exit.
  - After pair (N-1,N-1): go to DONE.
- DONE: done=1 for exactly one cycle, win=(all score fields ==10), then IDLE.
- Latency: done is high in the cycle after edge E0+N+N*N (E30 for N=5). Busy runs through the DONE cycle.
- score/win stay stable from DONE until the next accepted Start, which clears them at its edge.
- Start while busy is ignored; it is not queued.
- Start held high continuously: a new score is accepted in the first IDLE cycle after DONE, giving back-to-back operations 32 edges apart for N=5.
- Letters are compared as raw LW-bit values. No case folding; non-letter codes compare like any other value.
- Reset mid-operation aborts immediately to the reset values; no done pulse is produced.

Test Plan:
- Exact match, answer="ROBOT", guess="ROBOT", Start pulse -> done one cycle at E0+30; score=10'b1010101010; win=1; busy low the cycle after done.
- No common letters, answer="CRIMP", guess="VIVID"... with a trap: I is shared, so use guess="ZZZZZ" instead -> score=10'b0000000000, win=0.
- Duplicates vs green, answer="ROBOT", guess="OOOOO" -> score=10'b0010001000 (positions 1 and 3 green, rest gray, no yellows).
- Duplicate yellow limiting, answer="ABBOT", guess="BOBBY" -> score=10'b0101100000 (B yellow, O yellow, B green, B gray, Y gray), win=0.
- Start re-pulsed at E0+10 while busy, guess changed -> ignored; result matches the originally latched words; done only once.
- reset asserted at E0+15 -> busy, done, score, win are 0 immediately (asynchronously); no done pulse; next Start yields a correct, full-latency result.
